button_pulse_gen: RTL and testbench

BUTTON_PULSE_GEN -- requirements
Module: button_pulse_gen

---
 rtl/btn_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/button_pulse_gen.sv | 149 ++++++++++++++
 tb/tb_button_pulse_gen.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Purpose: shared types for the push-button pulse generator.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package btn_pkg;

    // Debounce / hold / repeat controller states.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRESS_DB   = 3'd1,
        HELD       = 3'd2,
        REPEAT     = 3'd3,
        RELEASE_DB = 3'd4
    } btn_state_t;

    // Largest of three cycle counts; sizes the shared state counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Purpose: two-flop synchronizer for one asynchronous bit.
// Latency: 2 clk edges from d to q.
// Backpressure: none; free-running.
//
// Ports: clk, reset (async active-low), d (async input), q (synchronized).
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_pulse_gen.sv
// Purpose: debounce a raw push-button, emit one-cycle pulses per press (plus optional auto-repeat).
// Latency: pulse/pressed rise after edge DEBOUNCE_CYCLES+2 (edge 0 = first edge sampling press).
// Backpressure: none; pulse is a single-cycle enable with no handshake.
//
// Ports: clk, reset (async active-low), btn_in (raw button), pulse (one-cycle
// enable per accepted press / repeat), pressed (debounced level, 1 = pressed).
module button_pulse_gen
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int REPEAT_EN       = 0,
    parameter int ACTIVE_LOW_BTN  = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic pulse,
    output logic pressed
);

    // The counter only ever reaches (limit - 1), so $clog2 of the largest
    // limit is always wide enough.
    localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    // Raw level of btn_in when the button is not pressed.
    localparam logic BTN_REL = (ACTIVE_LOW_BTN != 0) ? 1'b1 : 1'b0;

    logic             btn_sync;
    logic             btn_s;
    btn_state_t       state;
    btn_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             pulse_nxt;
    logic             pressed_nxt;

    sync_2ff #(
        .RST_VAL (BTN_REL)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (btn_sync)
    );

    // Normalize so btn_s = 1 means pressed regardless of board polarity.
    assign btn_s = btn_sync ^ BTN_REL;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pulse   <= 1'b0;
            pressed <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pulse   <= pulse_nxt;
            pressed <= pressed_nxt;
        end
    end

    // Every state change clears cnt, so each state times from its own entry.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pulse_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_nxt = PRESS_DB;
                    cnt_nxt   = '0;
                end
            end

            PRESS_DB: begin
                if (!btn_s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    pulse_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            HELD: begin
                if (!btn_s) begin
                    state_nxt = RELEASE_DB;
                    cnt_nxt   = '0;
                end else if (cnt == HOLD_LAST) begin
                    // Without auto-repeat cnt parks here until release.
                    if (REPEAT_EN != 0) begin
                        state_nxt = REPEAT;
                        cnt_nxt   = '0;
                        pulse_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            REPEAT: begin
                if (!btn_s) begin
                    state_nxt = RELEASE_DB;
                    cnt_nxt   = '0;
                end else if (cnt == REP_LAST) begin
                    cnt_nxt   = '0;
                    pulse_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            RELEASE_DB: begin
                // A press glitch during release returns to HELD silently and
                // restarts the hold timer.
                if (btn_s) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        pressed_nxt = (state_nxt == HELD) || (state_nxt == REPEAT) ||
                      (state_nxt == RELEASE_DB);
    end

endmodule

// File: tb/tb_button_pulse_gen.sv
// Purpose: self-checking bench for button_pulse_gen (three parameter variants).
// Latency: n/a.
// Backpressure: n/a.
module tb_button_pulse_gen;

    localparam int DB   = 4;
    localparam int HOLD = 8;
    localparam int REP  = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic press = 1'b0;
    logic btn_a, btn_r, btn_p;
    logic pulse_a, pressed_a, pulse_r, pressed_r, pulse_p, pressed_p;

    always #5 clk = ~clk;

    // Logical press drives active-low buttons inverted, active-high directly.
    assign btn_a = ~press;
    assign btn_r = ~press;
    assign btn_p = press;

    button_pulse_gen #(.DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP),
                       .REPEAT_EN(0), .ACTIVE_LOW_BTN(1)) dut_a (
        .clk(clk), .reset(reset), .btn_in(btn_a), .pulse(pulse_a), .pressed(pressed_a));

    button_pulse_gen #(.DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP),
                       .REPEAT_EN(1), .ACTIVE_LOW_BTN(1)) dut_r (
        .clk(clk), .reset(reset), .btn_in(btn_r), .pulse(pulse_r), .pressed(pressed_r));

    button_pulse_gen #(.DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP),
                       .REPEAT_EN(0), .ACTIVE_LOW_BTN(0)) dut_p (
        .clk(clk), .reset(reset), .btn_in(btn_p), .pulse(pulse_p), .pressed(pressed_p));

    // Behavioural model: counts runs of consecutive pressed / released
    // samples and the age of the current hold, then derives outputs.
    typedef struct packed {
        int   run;   // consecutive pressed samples while not pressed
        int   rel;   // consecutive released samples while pressed
        int   age;   // pressed samples since the hold (re)started
        logic pr;
        logic pl;
        logic d1;
        logic d2;
    } mdl_t;

    function automatic mdl_t step(input mdl_t m, input logic in, input logic rep);
        mdl_t n;
        logic s;
        n    = m;
        s    = m.d2;
        n.d2 = m.d1;
        n.d1 = in;
        n.pl = 1'b0;
        if (!m.pr) begin
            if (s) begin
                n.run = m.run + 1;
                if (n.run == DB + 1) begin
                    n.pr  = 1'b1;
                    n.pl  = 1'b1;
                    n.age = 0;
                    n.rel = 0;
                    n.run = 0;
                end
            end else begin
                n.run = 0;
            end
        end else begin
            if (s) begin
                if (m.rel > 0) begin
                    n.rel = 0;
                    n.age = 0;
                end else begin
                    n.age = m.age + 1;
                    if (rep && n.age >= HOLD && ((n.age - HOLD) % REP) == 0) n.pl = 1'b1;
                end
            end else begin
                n.rel = m.rel + 1;
                if (n.rel == DB + 1) begin
                    n.pr  = 1'b0;
                    n.rel = 0;
                    n.run = 0;
                end
            end
        end
        return n;
    endfunction

    mdl_t ma, mr;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ma <= '0;
            mr <= '0;
        end else begin
            ma <= step(ma, press, 1'b0);
            mr <= step(mr, press, 1'b1);
        end
    end

    int edge_no = 0;
    always @(posedge clk) edge_no <= edge_no + 1;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0b, expected %0b (edge %0d)", name, got, exp, edge_no);
        end
    endtask

    task automatic chk_i(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    typedef int q_t[$];

    function automatic q_t mkq(input int n, input int v0, input int v1 = 0,
                               input int v2 = 0, input int v3 = 0, input int v4 = 0);
        q_t q;
        int arr[5];
        arr = '{v0, v1, v2, v3, v4};
        for (int i = 0; i < n; i++) q.push_back(arr[i]);
        return q;
    endfunction

    function automatic string q2s(input q_t q);
        string s;
        s = "{";
        for (int i = 0; i < q.size() && i < 12; i++) s = {s, $sformatf(" %0d", q[i])};
        return {s, " }"};
    endfunction

    task automatic chk_q(input string name, input q_t got, input q_t exp);
        logic ok;
        vectors++;
        ok = (got.size() == exp.size());
        for (int i = 0; ok && i < exp.size(); i++) if (got[i] != exp[i]) ok = 1'b0;
        if (!ok) begin
            errors++;
            $display("FAIL %s: pulse edges %s, expected %s", name, q2s(got), q2s(exp));
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("pulse_a",   pulse_a,   ma.pl);
        chk("pressed_a", pressed_a, ma.pr);
        chk("pulse_p",   pulse_p,   ma.pl);
        chk("pressed_p", pressed_p, ma.pr);
        chk("pulse_r",   pulse_r,   mr.pl);
        chk("pressed_r", pressed_r, mr.pr);
    end

    // Edge-relative recording for the directed scenarios.
    int   t0 = 0;
    q_t   q_a, q_p, q_r, q_ma, q_mr;
    int   rise_a = -1;
    int   fall_a = -1;
    logic prev_a = 1'b0;

    task automatic clr();
        q_a.delete(); q_p.delete(); q_r.delete(); q_ma.delete(); q_mr.delete();
        rise_a = -1;
        fall_a = -1;
    endtask

    task automatic tick();
        @(negedge clk);
        if (pulse_a) q_a.push_back(edge_no - t0);
        if (pulse_p) q_p.push_back(edge_no - t0);
        if (pulse_r) q_r.push_back(edge_no - t0);
        if (ma.pl)   q_ma.push_back(edge_no - t0);
        if (mr.pl)   q_mr.push_back(edge_no - t0);
        if (pressed_a && !prev_a && rise_a < 0) rise_a = edge_no - t0;
        if (!pressed_a && prev_a && fall_a < 0) fall_a = edge_no - t0;
        prev_a = pressed_a;
    endtask

    initial begin
        logic found;
        int   len;

        // Reset state.
        repeat (3) tick();
        chk("rst_pulse_a",   pulse_a,   1'b0);
        chk("rst_pressed_a", pressed_a, 1'b0);
        chk("rst_pulse_r",   pulse_r,   1'b0);
        reset = 1'b1;
        repeat (5) tick();

        // Clean press, 30 cycles.
        clr();
        press = 1'b1;
        t0 = edge_no + 1;
        repeat (30) tick();
        press = 1'b0;
        repeat (15) tick();
        chk_q("clean_a", q_a, mkq(1, 6));
        chk_q("clean_p", q_p, mkq(1, 6));
        chk_q("clean_model", q_ma, mkq(1, 6));
        chk_i("clean_rise_a", rise_a, 6);

        // Press bounce: toggle every 2 cycles for 12 cycles, then hold.
        clr();
        for (int i = 0; i < 12; i++) begin
            press = ((i / 2) % 2) == 0;
            tick();
        end
        press = 1'b1;
        t0 = edge_no + 1;
        repeat (20) tick();
        press = 1'b0;
        repeat (15) tick();
        chk_q("bounce_a", q_a, mkq(1, 6));

        // Release bounce: one-cycle return to pressed during release.
        clr();
        press = 1'b1;
        t0 = edge_no + 1;
        repeat (20) tick();
        press = 1'b0;
        repeat (3) tick();
        press = 1'b1;
        tick();
        press = 1'b0;
        t0 = edge_no + 1;
        repeat (15) tick();
        chk_q("relbounce_a", q_a, mkq(1, 6));
        chk_i("relbounce_fall_a", fall_a, 6);

        // Auto-repeat: held for 24 edges.
        clr();
        press = 1'b1;
        t0 = edge_no + 1;
        repeat (24) tick();
        press = 1'b0;
        repeat (20) tick();
        chk_q("repeat_r", q_r, mkq(5, 6, 14, 17, 20, 23));
        chk_q("repeat_model", q_mr, mkq(5, 6, 14, 17, 20, 23));
        chk_q("repeat_a", q_a, mkq(1, 6));

        // Reset while in REPEAT, right after a repeat pulse.
        press = 1'b1;
        repeat (20) tick();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(posedge clk);
            #1;
            if (pulse_r) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            errors++;
            $display("FAIL repeat_wait: no repeat pulse within 10 cycles, expected one");
        end
        reset = 1'b0;
        #1;
        chk("rst_async_pulse_r",   pulse_r,   1'b0);
        chk("rst_async_pressed_r", pressed_r, 1'b0);
        repeat (3) tick();
        clr();
        reset = 1'b1;
        t0 = edge_no + 1;
        repeat (15) tick();
        chk_q("rst_held_a", q_a, mkq(1, 6));
        chk_q("rst_held_r", q_r, mkq(2, 6, 14));
        press = 1'b0;
        repeat (15) tick();

        // Randomized segments with occasional asynchronous reset.
        for (int seg = 0; seg < 400; seg++) begin
            if ($urandom_range(0, 9) < 7) len = $urandom_range(1, 3);
            else                          len = $urandom_range(5, 40);
            press = ~press;
            for (int k = 0; k < len; k++) begin
                tick();
                if ($urandom_range(0, 499) == 0) begin
                    #2 reset = 1'b0;
                    tick();
                    reset = 1'b1;
                end
            end
        end
        press = 1'b0;
        repeat (15) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
